uibi_dma: RTL and testbench

- Word-granular memory-to-memory copy engine; the initiator (master) end of the UIBI bus that timer-style peripherals answer as slaves.
- Configured by direct ports from the CPU-side config logic.
- Issues alternating single-beat read and write transfers on the UIBI bus.
- Raises a one-cycle interrupt pulse when the copy completes.

---
 rtl/uibi_dma.sv | 152 +++++++++++++++
 tb/tb_uibi_dma.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uibi_dma.sv
// uibi_dma: word-granular memory-to-memory copy engine, initiator end of the UIBI bus.
// Each word is one read beat, one bubble cycle, then one write beat; a one-cycle intr
// pulse marks completion. Define UIBI_DMA_FILL_EN to add a fill mode that writes a
// latched constant to the destination without issuing any reads.
module uibi_dma #(
  parameter int unsigned XLEN      = 32,
  parameter logic [1:0]  WORD_MODE = 2'b10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic [XLEN-1:0] cfg_src,
  input  logic [XLEN-1:0] cfg_dst,
  input  logic [XLEN-1:0] cfg_len,
`ifdef UIBI_DMA_FILL_EN
  input  logic            cfg_fill,
  input  logic [XLEN-1:0] cfg_fill_val,
`endif
  output logic            busy,
  output logic            done,
  output logic            intr,
  output logic            bus_req,
  output logic            bus_wen,
  output logic [1:0]      bus_mode,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_dat_o,
  input  logic [XLEN-1:0] bus_dat_i,
  input  logic            bus_ready
);

  localparam logic [XLEN-1:0] AlignMask = ~(XLEN'(3));
  localparam logic [XLEN-1:0] WordStep  = XLEN'(4);

  typedef enum logic [2:0] {StIdle, StRd, StRdata, StWr, StDone} state_e;

  state_e          state_q;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] dst_q;
  logic [XLEN-1:0] remain_q;
  logic            fill_q;

  logic [XLEN-1:0] src_al;
  logic [XLEN-1:0] dst_al;
  logic            start_fill;
  logic [XLEN-1:0] start_fill_val;

  // Byte addresses are forced onto word boundaries at start.
  assign src_al = cfg_src & AlignMask;
  assign dst_al = cfg_dst & AlignMask;

`ifdef UIBI_DMA_FILL_EN
  assign start_fill     = cfg_fill;
  assign start_fill_val = cfg_fill_val;
`else
  assign start_fill     = 1'b0;
  assign start_fill_val = '0;
`endif

  assign bus_mode = WORD_MODE;

  // Transfer FSM; every bus-facing output is registered here. bus_dat_o doubles as the
  // word buffer between the read and write beats (and holds the fill value in fill mode).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      remain_q  <= '0;
      fill_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      intr      <= 1'b0;
      bus_req   <= 1'b0;
      bus_wen   <= 1'b0;
      bus_addr  <= '0;
      bus_dat_o <= '0;
    end else begin
      intr <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            src_q    <= src_al;
            dst_q    <= dst_al;
            remain_q <= cfg_len;
            fill_q   <= start_fill;
            busy     <= 1'b1;
            done     <= 1'b0;
            if (cfg_len == '0) begin
              state_q <= StDone;
              intr    <= 1'b1;
            end else if (start_fill) begin
              state_q   <= StWr;
              bus_req   <= 1'b1;
              bus_wen   <= 1'b1;
              bus_addr  <= dst_al;
              bus_dat_o <= start_fill_val;
            end else begin
              state_q  <= StRd;
              bus_req  <= 1'b1;
              bus_wen  <= 1'b0;
              bus_addr <= src_al;
            end
          end
        end
        StRd: begin
          if (bus_ready) begin
            state_q <= StRdata;
            bus_req <= 1'b0;
          end
        end
        StRdata: begin
          // Slave read data is valid in this bubble cycle.
          state_q   <= StWr;
          bus_req   <= 1'b1;
          bus_wen   <= 1'b1;
          bus_addr  <= dst_q;
          bus_dat_o <= bus_dat_i;
        end
        StWr: begin
          if (bus_ready) begin
            src_q    <= src_q + WordStep;
            dst_q    <= dst_q + WordStep;
            remain_q <= remain_q - XLEN'(1);
            if (remain_q == XLEN'(1)) begin
              state_q   <= StDone;
              intr      <= 1'b1;
              bus_req   <= 1'b0;
              bus_wen   <= 1'b0;
              bus_addr  <= '0;
              bus_dat_o <= '0;
            end else if (fill_q) begin
              // Back-to-back writes; bus_dat_o keeps the fill value.
              bus_addr <= dst_q + WordStep;
            end else begin
              state_q   <= StRd;
              bus_wen   <= 1'b0;
              bus_addr  <= src_q + WordStep;
              bus_dat_o <= '0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uibi_dma.sv
// tb_uibi_dma: randomized self-checking bench for uibi_dma. A 2 KiB RAM slave answers the
// bus; a word-level reference model predicts the beat sequence, final memory and timing.
module tb_uibi_dma;
  localparam int unsigned XLEN     = 32;
  localparam int          MemWords = 512;

  typedef struct packed {
    logic            wen;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_start = 1'b0;
  logic [XLEN-1:0] cfg_src = '0;
  logic [XLEN-1:0] cfg_dst = '0;
  logic [XLEN-1:0] cfg_len = '0;
`ifdef UIBI_DMA_FILL_EN
  logic            cfg_fill = 1'b0;
  logic [XLEN-1:0] cfg_fill_val = '0;
`endif
  logic            busy, done, intr, bus_req, bus_wen;
  logic [1:0]      bus_mode;
  logic [XLEN-1:0] bus_addr, bus_dat_o;
  logic [XLEN-1:0] bus_dat_i = '0;
  logic            bus_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uibi_dma #(
    .XLEN      (XLEN),
    .WORD_MODE (2'b10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_src      (cfg_src),
    .cfg_dst      (cfg_dst),
    .cfg_len      (cfg_len),
`ifdef UIBI_DMA_FILL_EN
    .cfg_fill     (cfg_fill),
    .cfg_fill_val (cfg_fill_val),
`endif
    .busy         (busy),
    .done         (done),
    .intr         (intr),
    .bus_req      (bus_req),
    .bus_wen      (bus_wen),
    .bus_mode     (bus_mode),
    .bus_addr     (bus_addr),
    .bus_dat_o    (bus_dat_o),
    .bus_dat_i    (bus_dat_i),
    .bus_ready    (bus_ready)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave RAM: writes land at the accepting edge, read data is registered for the next cycle.
  logic [XLEN-1:0] mem [MemWords];
  always @(posedge clk) begin
    if (!rst && bus_req && bus_ready) begin
      if (bus_wen) mem[bus_addr[10:2]] <= bus_dat_o;
      else         bus_dat_i <= mem[bus_addr[10:2]];
    end
  end

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and ready driver: picks ready for the coming edge, logs accepted beats,
  // counts intr pulses and flags request changes during a stall.
  beat_t log_q[$];
  int    ready_pct = 100;
  bit    stall_wr = 1'b0;
  int    intr_cnt = 0;
  int    intr_cyc = 0;
  int    req_seen = 0;
  int    stall_err = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  always @(negedge clk) begin
    beat_t cur;
    cur = {bus_wen, bus_addr, bus_dat_o};
    bus_ready = (stall_wr && bus_wen) ? 1'b0 : (int'($urandom_range(99, 0)) < ready_pct);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus_req || cur != prev_beat)) stall_err++;
      if (bus_req) req_seen++;
      if (intr) begin
        intr_cnt++;
        intr_cyc = cyc;
      end
      if (bus_req && bus_ready) log_q.push_back(cur);
      prev_stall = bus_req && !bus_ready;
      prev_beat  = cur;
    end
  end

  // One job: model, start, optional cfg_start pulse at loop step 'glitch', then compare.
  task automatic run_copy(input string tag, input logic [XLEN-1:0] src, input logic [XLEN-1:0] dst,
                          input int len, input int pct, input bit fill,
                          input logic [XLEN-1:0] fill_val, input int glitch);
    logic [XLEN-1:0] exp_mem [MemWords];
    beat_t           exp_q[$];
    logic [XLEN-1:0] s, d;
    int              t0, bound, k, diffs, n;
    for (int i = 0; i < MemWords; i++) exp_mem[i] = mem[i];
    s = src & ~32'h3;
    d = dst & ~32'h3;
    for (int i = 0; i < len; i++) begin
      if (fill) begin
        exp_q.push_back({1'b1, d, fill_val});
        exp_mem[d[10:2]] = fill_val;
      end else begin
        exp_q.push_back({1'b0, s, 32'h0});
        exp_q.push_back({1'b1, d, exp_mem[s[10:2]]});
        exp_mem[d[10:2]] = exp_mem[s[10:2]];
      end
      s += 4;
      d += 4;
    end

    @(negedge clk);
    log_q.delete();
    intr_cnt  = 0;
    req_seen  = 0;
    stall_err = 0;
    ready_pct = pct;
    cfg_src   = src;
    cfg_dst   = dst;
    cfg_len   = len;
`ifdef UIBI_DMA_FILL_EN
    cfg_fill     = fill;
    cfg_fill_val = fill_val;
`endif
    cfg_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
    check_eq({tag, ".busy_after_start"}, busy, 1);
    check_eq({tag, ".done_cleared"}, done, 0);

    bound = 60 * len + 40;
    k = 0;
    while (k < bound && (intr_cnt == 0 || k <= glitch)) begin
      if (k == glitch) begin
        cfg_start = 1'b1;
        cfg_src   = 32'h600;
        cfg_len   = 7;
      end else begin
        cfg_start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    cfg_start = 1'b0;
    repeat (4) @(negedge clk);

    check_eq({tag, ".intr_count"}, intr_cnt, 1);
    if (pct == 100) begin
      check_eq({tag, ".intr_latency"}, intr_cyc - t0, fill ? len + 1 : 3 * len + 1);
      check_eq({tag, ".req_cycles"}, req_seen, exp_q.size());
    end
    check_eq({tag, ".busy_end"}, busy, 0);
    check_eq({tag, ".done_end"}, done, 1);
    check_eq({tag, ".beats"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("%s.beat%0d", tag, i), log_q[i], exp_q[i]);
    diffs = 0;
    for (int i = 0; i < MemWords; i++) if (mem[i] !== exp_mem[i]) diffs++;
    check_eq({tag, ".mem_diffs"}, diffs, 0);
    check_eq({tag, ".stall_stable"}, stall_err, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < MemWords; i++) mem[i] = $urandom();
    for (int i = 0; i < 4; i++) mem[(32'h100 >> 2) + i] = 32'hA0 + i;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.intr", intr, 0);
    check_eq("rst.bus_req", bus_req, 0);
    check_eq("rst.bus_wen", bus_wen, 0);
    check_eq("rst.bus_addr", bus_addr, 0);
    check_eq("rst.bus_dat_o", bus_dat_o, 0);
    check_eq("rst.bus_mode", bus_mode, 2'b10);
    rst = 1'b0;

    run_copy("basic", 32'h100, 32'h200, 4, 100, 1'b0, '0, -1);
    for (int i = 0; i < 4; i++) check_eq($sformatf("basic.dst%0d", i), mem[(32'h200 >> 2) + i],
                                         32'hA0 + i);
    run_copy("stall", 32'h100, 32'h280, 4, 70, 1'b0, '0, -1);
    run_copy("len0", 32'h40, 32'h80, 0, 100, 1'b0, '0, -1);
    run_copy("unalign", 32'h103, 32'h402, 1, 100, 1'b0, '0, -1);
    run_copy("wrap", 32'h500, 32'hFFFF_FFFC, 2, 100, 1'b0, '0, -1);
    run_copy("restart_busy", 32'h10, 32'h700, 5, 100, 1'b0, '0, 4);
    run_copy("restart_done", 32'h20, 32'h720, 2, 100, 1'b0, '0, 6);

    for (int r = 0; r < 8; r++) begin
      logic [XLEN-1:0] rs, rd;
      int              rl, rp;
      rl = $urandom_range(6, 1);
      rs = ($urandom() & 32'hFFFF_F800) | ($urandom_range(249, 0) << 2) | $urandom_range(3, 0);
      rd = ($urandom() & 32'hFFFF_F800) | ($urandom_range(505, 256) << 2) | $urandom_range(3, 0);
      rp = (r % 2 == 0) ? 100 : int'($urandom_range(100, 40));
      run_copy($sformatf("rand%0d", r), rs, rd, rl, rp, 1'b0, '0, -1);
    end

    // Reset while a write beat is stalled.
    @(negedge clk);
    ready_pct = 100;
    stall_wr  = 1'b1;
    intr_cnt  = 0;
    cfg_src   = 32'h40;
    cfg_dst   = 32'h600;
    cfg_len   = 3;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    k = 0;
    while (k < 50 && !(bus_req && bus_wen)) begin
      @(negedge clk);
      k++;
    end
    check_eq("rst_wr.reached_wr", bus_req && bus_wen, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_wr.bus_req", bus_req, 0);
    check_eq("rst_wr.busy", busy, 0);
    check_eq("rst_wr.done", done, 0);
    check_eq("rst_wr.intr", intr, 0);
    @(negedge clk);
    rst      = 1'b0;
    stall_wr = 1'b0;
    req_seen = 0;
    repeat (20) @(negedge clk);
    check_eq("rst_wr.no_intr", intr_cnt, 0);
    check_eq("rst_wr.no_req", req_seen, 0);

`ifdef UIBI_DMA_FILL_EN
    run_copy("fill", 32'h0, 32'h300, 8, 100, 1'b1, 32'hDEAD_BEEF, -1);
    run_copy("fill_stall", 32'h0, 32'h340, 5, 60, 1'b1, 32'h1234_5678, -1);
    run_copy("copy_after_fill", 32'h100, 32'h380, 3, 100, 1'b0, '0, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
